// File: rtl/mem2axi_bridge_if.sv
// AXI4 signal bundle for the memory-to-AXI bridge: master drives requests, slave drives responses.
interface axi_intf;
  localparam int unsigned ID_W   = 13;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/mem2axi_bridge.sv
// Turns single-word memory-port requests into single-beat AXI4 transactions, one outstanding.
module mem2axi_bridge #(
  parameter logic [12:0] AXI_ID = 13'h0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        s_cs,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [3:0]  s_byte,
  input  logic [31:0] s_di,
  output logic [31:0] s_do,
  output logic        s_busy,
  output logic        s_err,
  axi_intf.master     m_axi_intf
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   do_d;
  logic                busy_d, err_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      s_do      <= '0;
      s_busy    <= 1'b0;
      s_err     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state     <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      s_do      <= do_d;
      s_busy    <= busy_d;
      s_err     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  // In WREQ a dropped awvalid/wvalid marks that channel's handshake as done.
  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    do_d      = s_do;
    err_d     = s_err;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    case (state)
      IDLE: begin
        if (s_cs) begin
          addr_d = s_addr;
          err_d  = 1'b0;
          if (s_we) begin
            data_d    = s_di;
            strb_d    = s_byte;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WREQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RREQ;
          end
        end
      end
      WREQ: begin
        if (awvalid_q && m_axi_intf.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_intf.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (m_axi_intf.bvalid) begin
          bready_d = 1'b0;
          err_d    = m_axi_intf.bresp[1];
          state_d  = IDLE;
        end
      end
      RREQ: begin
        if (m_axi_intf.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RRESP;
        end
      end
      RRESP: begin
        if (m_axi_intf.rvalid) begin
          rready_d = 1'b0;
          do_d     = m_axi_intf.rdata;
          err_d    = m_axi_intf.rresp[1];
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign m_axi_intf.awid    = AXI_ID;
  assign m_axi_intf.awaddr  = addr_q;
  assign m_axi_intf.awlen   = 8'd0;
  assign m_axi_intf.awsize  = 3'd2;
  assign m_axi_intf.awburst = 2'b01;
  assign m_axi_intf.awlock  = 1'b0;
  assign m_axi_intf.awcache = 4'd0;
  assign m_axi_intf.awprot  = 3'd0;
  assign m_axi_intf.awqos   = 4'd0;
  assign m_axi_intf.awvalid = awvalid_q;
  assign m_axi_intf.wdata   = data_q;
  assign m_axi_intf.wstrb   = strb_q;
  assign m_axi_intf.wlast   = 1'b1;
  assign m_axi_intf.wvalid  = wvalid_q;
  assign m_axi_intf.bready  = bready_q;
  assign m_axi_intf.arid    = AXI_ID;
  assign m_axi_intf.araddr  = addr_q;
  assign m_axi_intf.arlen   = 8'd0;
  assign m_axi_intf.arsize  = 3'd2;
  assign m_axi_intf.arburst = 2'b01;
  assign m_axi_intf.arlock  = 1'b0;
  assign m_axi_intf.arcache = 4'd0;
  assign m_axi_intf.arprot  = 3'd0;
  assign m_axi_intf.arqos   = 4'd0;
  assign m_axi_intf.arvalid = arvalid_q;
  assign m_axi_intf.rready  = rready_q;

  // Response IDs, rlast and the low resp bit carry nothing the initiator needs.
  logic unused_resp;
  assign unused_resp = ^{m_axi_intf.bid, m_axi_intf.bresp[0], m_axi_intf.rid,
                         m_axi_intf.rresp[0], m_axi_intf.rlast};
endmodule
